// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a word-addressed data memory.
//
// Takes one pipeline request at a time and turns its byte address into a word
// index. Byte and halfword loads are sign- or zero-extended. Byte and halfword
// stores are done as read-modify-write. Every memory-side output is registered.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while IDLE)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         zero-extend loads (lbu/lhu)
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             misaligned, illegal size or out-of-range access
//   MemRead, MemWrite    memory strobes (never both high)
//   Addr, Wdata, Rdata   word index, write word, read word
//   stat_*               load/store/error counters
//
// Optional feature macro: MEMCTL_STATS_EN. When it is defined, saturating
// statistics counters are built. When it is undefined, the stat ports read 0.
module mem_access_ctrl #(
  parameter int DEPTH  = 512,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       Addr,
  output logic [31:0]       Wdata,
  input  logic [31:0]       Rdata,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errors
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    SAMPLE = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

  // Select a byte or halfword lane from a memory word, then extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge the low byte or halfword of the store data into the selected lane.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_t      state, next_state;
  logic        lat_write, lat_unsigned;
  logic [1:0]  lat_size, lat_lane;
  logic [31:0] lat_wdata;
  logic        accept, acc_err;
  logic        req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [31:0] resp_rdata_d, addr_d, wdata_d;

  // Accept decode and error classification of the incoming request.
  always_comb begin
    accept  = req_valid && (state == IDLE);
    acc_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
              (req_addr[31:2] >= DEPTH_IDX);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Latch the request attributes at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_lane     <= 2'b00;
      lat_wdata    <= 32'h0;
    end else if (accept) begin
      lat_write    <= req_write;
      lat_unsigned <= req_unsigned;
      lat_size     <= req_size;
      lat_lane     <= req_addr[1:0];
      lat_wdata    <= req_wdata;
    end else begin
      lat_write    <= lat_write;
      lat_unsigned <= lat_unsigned;
      lat_size     <= lat_size;
      lat_lane     <= lat_lane;
      lat_wdata    <= lat_wdata;
    end
  end

  // Next-state logic. A word store does not need the read half of RMW.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!accept)                                next_state = IDLE;
        else if (acc_err)                           next_state = DONE;
        else if (req_write && (req_size == 2'b10))  next_state = WR;
        else                                        next_state = RD;
      end
      RD:      next_state = SAMPLE;
      SAMPLE:  next_state = lat_write ? WR : DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs. They are derived from next_state,
  // so each strobe is high during exactly the cycles its state is occupied.
  always_comb begin
    req_ready_d  = (next_state == IDLE);
    mem_read_d   = (next_state == RD) || (next_state == SAMPLE);
    mem_write_d  = (next_state == WR);
    resp_valid_d = (next_state == DONE);
    // Only the error path goes IDLE -> DONE directly.
    resp_err_d   = (next_state == DONE) && (state == IDLE);
    // Only a load goes SAMPLE -> DONE.
    if ((next_state == DONE) && (state == SAMPLE))
      resp_rdata_d = load_extend(Rdata, lat_size, lat_unsigned, lat_lane);
    else
      resp_rdata_d = 32'h0;
    // Addr only moves at accept, so it is stable across the whole access.
    if (accept && !acc_err) addr_d = {2'b00, req_addr[31:2]};
    else                    addr_d = Addr;
    if ((state == IDLE) && (next_state == WR))
      wdata_d = req_wdata;
    else if ((state == SAMPLE) && (next_state == WR))
      wdata_d = store_merge(Rdata, lat_wdata, lat_size, lat_lane);
    else
      wdata_d = Wdata;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Addr       <= 32'h0;
      Wdata      <= 32'h0;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      MemRead    <= mem_read_d;
      MemWrite   <= mem_write_d;
      Addr       <= addr_d;
      Wdata      <= wdata_d;
    end
  end

`ifdef MEMCTL_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  logic [STAT_W-1:0] cnt_loads, cnt_stores, cnt_errors;

  // Saturating counters. Each one steps while the matching request is in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_loads  <= {STAT_W{1'b0}};
      cnt_stores <= {STAT_W{1'b0}};
      cnt_errors <= {STAT_W{1'b0}};
    end else if (state == DONE) begin
      if (resp_err) begin
        if (cnt_errors != STAT_MAX) cnt_errors <= cnt_errors + STAT_ONE;
        else                        cnt_errors <= cnt_errors;
      end else if (lat_write) begin
        if (cnt_stores != STAT_MAX) cnt_stores <= cnt_stores + STAT_ONE;
        else                        cnt_stores <= cnt_stores;
      end else begin
        if (cnt_loads != STAT_MAX)  cnt_loads <= cnt_loads + STAT_ONE;
        else                        cnt_loads <= cnt_loads;
      end
    end else begin
      cnt_loads  <= cnt_loads;
      cnt_stores <= cnt_stores;
      cnt_errors <= cnt_errors;
    end
  end

  assign stat_loads  = cnt_loads;
  assign stat_stores = cnt_stores;
  assign stat_errors = cnt_errors;
`else
  assign stat_loads  = {STAT_W{1'b0}};
  assign stat_stores = {STAT_W{1'b0}};
  assign stat_errors = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized bench for mem_access_ctrl.
// A synchronous-read word memory is attached to the DUT. A reference word
// array predicts the outcome of every request: the response cycle, the read
// and write strobe cycles, the write word, and the load data.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, Addr, Wdata, Rdata;
  logic [15:0] stat_loads, stat_stores, stat_errors;

  logic [31:0] mem [0:511];
  logic [31:0] ref_mem [0:511];
  logic        pre_en;
  logic [8:0]  pre_idx;
  logic [31:0] pre_val;

  int checks = 0;
  int failures = 0;
  int exp_loads = 0, exp_stores = 0, exp_errors = 0;

  mem_access_ctrl #(.DEPTH(512), .STAT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr),
    .Wdata(Wdata), .Rdata(Rdata), .stat_loads(stat_loads),
    .stat_stores(stat_stores), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  // Data memory with a synchronous read port and a bench-side preload port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (MemWrite) mem[Addr[8:0]] <= Wdata;
    if (MemRead) Rdata <= mem[Addr[8:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 9'(idx); pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and compare everything it does against the reference.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd);
    int idx, sh, resp_k, resp_n;
    logic err;
    logic [31:0] word, mask, exp_rdata, new_word, got_rdata, wa, wdv;
    logic got_err, both;
    logic [7:0] exp_rd, exp_wr, rd_m, wr_m;
    int exp_resp;
    idx  = int'(a[31:2]);
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (idx >= 512);
    word = err ? 32'h0 : ref_mem[idx];
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : (sz == 2'd1) ? 16 * int'(a[1]) : 0;
    exp_rdata = 32'h0;
    new_word  = word;
    if (err) begin
      exp_resp = 1; exp_rd = 8'h00; exp_wr = 8'h00; exp_errors++;
    end else if (!w) begin
      exp_resp = 3; exp_rd = 8'b0000_0110; exp_wr = 8'h00; exp_loads++;
      exp_rdata = (word >> sh) & mask;
      if (!u && sz == 2'd0 && exp_rdata[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
      if (!u && sz == 2'd1 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
    end else begin
      exp_stores++;
      new_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
      if (sz == 2'd2) begin
        exp_resp = 2; exp_rd = 8'h00; exp_wr = 8'b0000_0010;
      end else begin
        exp_resp = 4; exp_rd = 8'b0000_0110; exp_wr = 8'b0000_1000;
      end
    end
    @(negedge clk);
    check({tag, ":ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    rd_m = 8'h00; wr_m = 8'h00; both = 1'b0; resp_k = 0; resp_n = 0;
    got_rdata = 32'h0; got_err = 1'b0; wa = 32'h0; wdv = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble the request lines to prove they were latched at accept.
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
      end
      if (MemRead) rd_m[k] = 1'b1;
      if (MemWrite) begin wr_m[k] = 1'b1; wa = Addr; wdv = Wdata; end
      if (MemRead && MemWrite) both = 1'b1;
      if (resp_valid) begin
        resp_n++;
        if (resp_k == 0) begin resp_k = k; got_rdata = resp_rdata; got_err = resp_err; end
      end
    end
    check({tag, ":resp_cycle"}, 32'(resp_k), 32'(exp_resp));
    check({tag, ":resp_count"}, 32'(resp_n), 32'h1);
    check({tag, ":read_cycles"}, {24'h0, rd_m}, {24'h0, exp_rd});
    check({tag, ":write_cycles"}, {24'h0, wr_m}, {24'h0, exp_wr});
    check({tag, ":rw_overlap"}, {31'h0, both}, 32'h0);
    check({tag, ":rdata"}, got_rdata, exp_rdata);
    check({tag, ":err"}, {31'h0, got_err}, {31'h0, err});
    if (exp_wr != 8'h00) begin
      check({tag, ":waddr"}, wa, 32'(idx));
      check({tag, ":wdata"}, wdv, new_word);
      ref_mem[idx] = new_word;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, ":resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, ":resp_err"}, {31'h0, resp_err}, 32'h0);
    check({tag, ":resp_rdata"}, resp_rdata, 32'h0);
    check({tag, ":MemRead"}, {31'h0, MemRead}, 32'h0);
    check({tag, ":MemWrite"}, {31'h0, MemWrite}, 32'h0);
    check({tag, ":Addr"}, Addr, 32'h0);
    check({tag, ":Wdata"}, Wdata, 32'h0);
  endtask

  task automatic check_stats(input string tag);
`ifdef MEMCTL_STATS_EN
    check({tag, ":stat_loads"}, {16'h0, stat_loads}, 32'(exp_loads));
    check({tag, ":stat_stores"}, {16'h0, stat_stores}, 32'(exp_stores));
    check({tag, ":stat_errors"}, {16'h0, stat_errors}, 32'(exp_errors));
`else
    check({tag, ":stat_loads"}, {16'h0, stat_loads}, 32'h0);
    check({tag, ":stat_stores"}, {16'h0, stat_stores}, 32'h0);
    check({tag, ":stat_errors"}, {16'h0, stat_errors}, 32'h0);
`endif
  endtask

  initial begin
    int idx, ms_w, ms_r, ms_v;
    logic [1:0] sz;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 9'h0; pre_val = 32'h0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check_stats("reset");

    // Memory image for the directed and random phases.
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int i = 500; i < 512; i++) preload(i, $urandom);
    preload(3, 32'h8899_AABB);

    do_req("lb13",   1'b0, 2'd0, 1'b0, 32'd13, 32'h0);
    do_req("lhu14",  1'b0, 2'd1, 1'b1, 32'd14, 32'h0);
    do_req("lh14",   1'b0, 2'd1, 1'b0, 32'd14, 32'h0);
    do_req("sb12",   1'b1, 2'd0, 1'b0, 32'd12, 32'h1234_5611);
    do_req("lw12",   1'b0, 2'd2, 1'b0, 32'd12, 32'h0);
    do_req("sw16",   1'b1, 2'd2, 1'b0, 32'd16, 32'hDEAD_BEEF);
    do_req("lw16",   1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    do_req("lw18",   1'b0, 2'd2, 1'b0, 32'd18, 32'h0);
    do_req("lh2049", 1'b0, 2'd1, 1'b0, 32'd2049, 32'h0);
    do_req("lw2048", 1'b0, 2'd2, 1'b0, 32'd2048, 32'h0);
    do_req("lw2044", 1'b0, 2'd2, 1'b0, 32'd2044, 32'h0);
    do_req("size11", 1'b0, 2'd3, 1'b0, 32'd8, 32'h0);
    do_req("sh_err", 1'b1, 2'd1, 1'b0, 32'd21, 32'hFFFF_FFFF);
    do_req("sh22",   1'b1, 2'd1, 1'b0, 32'd22, 32'hAAAA_5A5A);
    do_req("lb23u",  1'b0, 2'd0, 1'b1, 32'd23, 32'h0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) idx = $urandom_range(505, 520);
      else                           idx = $urandom_range(0, 15);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = {idx[29:0], 2'($urandom_range(0, 3))};
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    @(negedge clk);
    check_stats("stats");

    // Reset while the sub-word store sits in SAMPLE: no write and no response.
    preload(5, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'd20; req_wdata = 32'h1234_ABCD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst:read_t1", {31'h0, MemRead}, 32'h1);
    @(negedge clk);
    check("rst:read_t2", {31'h0, MemRead}, 32'h1);
    reset = 1'b1;
    ms_w = 0; ms_r = 0; ms_v = 0;
    @(negedge clk);
    if (MemWrite) ms_w++;
    if (MemRead) ms_r++;
    if (resp_valid) ms_v++;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_rst");
    exp_loads = 0; exp_stores = 0; exp_errors = 0;
    check_stats("after_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (MemWrite) ms_w++;
      if (resp_valid) ms_v++;
    end
    check("rst:no_write", 32'(ms_w), 32'h0);
    check("rst:read_drop", 32'(ms_r), 32'h0);
    check("rst:no_resp", 32'(ms_v), 32'h0);
    do_req("lw20", 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    check("rst:word5", ref_mem[5], 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage load/store initiator that drives the word-addressed data memory port: MemRead, MemWrite, Addr, Wdata, Rdata.
- Accepts one pipeline memory request at a time and converts byte addresses to word indices.
- Performs sign/zero-extended byte and halfword loads, and byte/halfword stores by read-modify-write.
- Returns a one-cycle response; the pipeline holds the MEM stage while req_ready is low.

Parameters:
DEPTH, 512, number of 32-bit words in the data memory; word index >= DEPTH is out of range
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  pipeline presents a request
req_ready  output  1  controller idle, can accept
req_write  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  input  1  loads only: 1=zero-extend (lbu/lhu)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  with resp_valid: misaligned, illegal size, or out of range
MemRead  output  1  to data memory
MemWrite  output  1  to data memory
Addr  output  32  word index = req_addr[31:2]
Wdata  output  32  full word to write
Rdata  input  32  word read from memory
stat_loads, stat_stores, stat_errors  output  STAT_W each  counters (optional feature)

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; MemRead=0; MemWrite=0; Addr=0; Wdata=0.
- All memory-side outputs are registered, glitch-free, and stable for a whole cycle. The memory write is level-sensitive, so Addr and Wdata must not change while MemWrite=1.
- Accept: req_valid && req_ready in IDLE. Latch write, size, unsigned, addr and wdata. req_ready=0 from the next cycle until the controller returns to IDLE.
- Error check at accept. An error is any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH. On error go straight to DONE with resp_err=1; no memory access is ever issued.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
- FSM states and transitions:
  - IDLE: on accepting a word store go to WR; on any other valid request go to RD.
  - RD: MemRead=1, Addr=index; go to SAMPLE.
  - SAMPLE: MemRead held at 1. Capture Rdata. A load extends the selected lane into the data register and goes to DONE. A store merges req_wdata[7:0] or [15:0] into the selected lane and goes to WR.
  - WR: MemWrite=1 for exactly one cycle with Addr and Wdata (merged word, or req_wdata for a word store); go to DONE.
  - DONE: resp_valid=1, resp_rdata and resp_err driven; go to IDLE. MemRead and MemWrite are 0.
- Latency, with accept at edge T: load resp_valid in cycle T+3; word store MemWrite in T+1 and resp in T+2; sub-word store MemWrite in T+3 and resp in T+4; error resp in T+1.
- Back-to-back requests: next accept occurs the cycle after DONE, when req_ready=1 again. No request overlap.
- Reset mid-operation: returns to IDLE on the next edge. MemRead and MemWrite drop in that same cycle, no pending write is issued, and no resp_valid is produced for the aborted request.
- MemRead and MemWrite are never both 1.

Optional Feature:
MEMCTL_STATS_EN
- Defined: stat_loads, stat_stores and stat_errors each increment by 1 in the DONE cycle of the matching request. Errors count only in stat_errors. Counters saturate at all-ones and clear on reset.
- Undefined: the counter registers are absent and the stat ports are tied to 0. The port list is unchanged.

Test Plan:
- Preload word 3=0x8899AABB; LB addr 13 -> MemRead in T+1..T+2, resp_valid T+3, resp_rdata=0xFFFFFFAA, resp_err=0.
- Same preload; LHU addr 14 -> resp_rdata=0x00008899; LH addr 14 -> 0xFFFF8899.
- Same preload; SB addr 12 wdata 0x12345611 -> MemWrite in T+3 only, Addr=3, Wdata=0x8899AA11, resp T+4; a later LW addr 12 returns 0x8899AA11.
- SW addr 16 wdata 0xDEADBEEF -> MemRead never 1, MemWrite in T+1 with Addr=4, resp T+2; LW addr 16 returns 0xDEADBEEF.
- LW addr 18 -> resp T+1 with resp_err=1, no MemRead/MemWrite. LH addr 2049 -> err. LW addr 2048 (index 512) -> err. size=11 -> err.
- SH addr 20 with reset asserted in SAMPLE cycle -> MemWrite never asserts, word 5 unchanged, req_ready=1 and all outputs at reset values the cycle after reset deasserts; with MEMCTL_STATS_EN, all counters=0.
